// File: rtl/ram8_arbiter_pkg.sv
// ==========================================================================
// hack_mem_pkg : shared word type and arbiter state encoding. Rev 1.0
// ==========================================================================
`default_nettype none

package hack_mem_pkg;
    localparam int WORD_W = 16;
    typedef logic [WORD_W-1:0] word_t;
    typedef enum logic [0:0] {ARB_INIT = 1'b0, ARB_RUN = 1'b1} arb_state_t;
endpackage

`default_nettype wire

// File: rtl/ram8_arbiter_if.sv
// ==========================================================================
// ram8_arbiter_if : two-requester memory bus with shared read data. Rev 1.0
// ==========================================================================
`default_nettype none

interface ram8_arbiter_if #(
    parameter int ADDR_W = 3
);
    import hack_mem_pkg::*;

    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    word_t             wdata0;
    logic              gnt0;
    logic              rvalid0;
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    word_t             wdata1;
    logic              gnt1;
    logic              rvalid1;
    word_t             rdata;
    logic              init_done;

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
        input  gnt0, rvalid0, gnt1, rvalid1, rdata, init_done
    );

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
        output gnt0, rvalid0, gnt1, rvalid1, rdata, init_done
    );
endinterface

`default_nettype wire

// File: rtl/ram8_arbiter_arb_rr2.sv
// ==========================================================================
// arb_rr2 : two-way arbiter, round-robin or fixed priority when
// RAM8_ARB_FIXED_PRIORITY_EN is defined. Rev 1.0
// ==========================================================================
`default_nettype none

module arb_rr2 (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  i_en,
    input  wire  i_req0,
    input  wire  i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);
`ifdef RAM8_ARB_FIXED_PRIORITY_EN
    assign o_gnt0 = i_en & i_req0;
    assign o_gnt1 = i_en & i_req1 & ~i_req0;
`else
    // r_ptr names the port that wins the next contention.
    logic r_ptr;

    assign o_gnt0 = i_en & i_req0 & (~i_req1 | ~r_ptr);
    assign o_gnt1 = i_en & i_req1 & (~i_req0 | r_ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_ptr <= 1'b0;
        else if (o_gnt0) r_ptr <= 1'b1;
        else if (o_gnt1) r_ptr <= 1'b0;
    end
`endif
endmodule

`default_nettype wire

// File: rtl/register16.sv
// ==========================================================================
// register16 : 16-bit load-enabled storage word, no reset. Rev 1.0
// ==========================================================================
`default_nettype none

module register16
    import hack_mem_pkg::*;
(
    input  wire   i_clk,
    input  wire   i_load,
    input  word_t i_in,
    output word_t o_out
);
    word_t r_q;

    always_ff @(posedge i_clk) begin
        if (i_load) r_q <= i_in;
    end

    assign o_out = r_q;
endmodule

`default_nettype wire

// File: rtl/ram8_arbiter.sv
// ==========================================================================
// ram8_arbiter : register16 bank shared by two ports, init sweep after reset.
// Option RAM8_ARB_FIXED_PRIORITY_EN selects fixed priority. Rev 1.0
// ==========================================================================
`default_nettype none

module ram8_arbiter
    import hack_mem_pkg::*;
#(
    parameter int    DEPTH      = 8,
    parameter word_t INIT_VALUE = 16'h0000,
    parameter int    ADDR_W     = $clog2(DEPTH)
) (
    input wire            clock,
    input wire            reset_n,
    ram8_arbiter_if.slave bus
);
    localparam logic [0:0] S_INIT = ARB_INIT;
    localparam logic [0:0] S_RUN  = ARB_RUN;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    word_t             r_rdata;
    logic              r_rvalid0;
    logic              r_rvalid1;

    logic              w_run;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_wr;
    logic              w_rd;
    logic [ADDR_W-1:0] w_addr;
    word_t             w_wdata;
    word_t             w_din;
    logic [DEPTH-1:0]  w_load;
    word_t             w_word [DEPTH];

    assign w_run = (r_state == S_RUN);

    arb_rr2 u_arb (
        .clk    (clock),
        .rst_n  (reset_n),
        .i_en   (w_run),
        .i_req0 (bus.req0),
        .i_req1 (bus.req1),
        .o_gnt0 (w_gnt0),
        .o_gnt1 (w_gnt1)
    );

    assign w_addr  = w_gnt1 ? bus.addr1  : bus.addr0;
    assign w_wdata = w_gnt1 ? bus.wdata1 : bus.wdata0;
    assign w_wr    = (w_gnt0 & bus.we0)  | (w_gnt1 & bus.we1);
    assign w_rd    = (w_gnt0 & ~bus.we0) | (w_gnt1 & ~bus.we1);
    assign w_din   = w_run ? w_wdata : INIT_VALUE;

    // During the sweep the counter owns the load enables; afterwards the granted write does.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            assign w_load[gi] = w_run ? (w_wr && (w_addr == ADDR_W'(gi)))
                                      : (r_cnt == ADDR_W'(gi));
            register16 u_reg (
                .i_clk  (clock),
                .i_load (w_load[gi]),
                .i_in   (w_din),
                .o_out  (w_word[gi])
            );
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
        end else if (r_state == S_INIT) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == ADDR_W'(DEPTH - 1)) r_state <= S_RUN;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_rvalid0 <= w_gnt0 & ~bus.we0;
            r_rvalid1 <= w_gnt1 & ~bus.we1;
            if (w_rd) r_rdata <= w_word[w_addr];
        end
    end

    assign bus.gnt0      = w_gnt0;
    assign bus.gnt1      = w_gnt1;
    assign bus.rvalid0   = r_rvalid0;
    assign bus.rvalid1   = r_rvalid1;
    assign bus.rdata     = r_rdata;
    assign bus.init_done = w_run;
endmodule

`default_nettype wire
